sobel_edge_writer: RTL and testbench
====================================

Name: sobel_edge_writer

Overview:
- Sink for the Sobel core's edge output. Collects the 1-bit edge decision (Dop) for each qualified output pixel and packs 8 pixels per byte, LSB first.
- Buffers packed bytes in a small FIFO and writes them to an edge-map memory through a valid/ready write port.
- Counts edge pixels and signals Done once the full frame is written.
- Sits between the Sobel core outputs and the edge-map RAM / host readback.

Parameters:
- IMG_W, 256, pixels per row.
- IMG_H, 256, rows per frame.
- ADDR_W, 13, byte address width; must satisfy 2^ADDR_W >= ceil(IMG_W*IMG_H/8).
- FIFO_DEPTH, 4, packed-byte buffer entries; power of 2, >= 2.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous reset, active-high.
- Start  in  1  level; a high level in IDLE begins a frame.
- Valid  in  1  Dop qualifier; driven by Sobel isReady && !Finish && state==2.
- Dop  in  1  edge bit for the current pixel, raster order.
- WrReady  in  1  memory accepts a write this cycle.
- WrEn  out  1  write request (FIFO non-empty).
- WrAddr  out  ADDR_W  byte address of the FIFO head.
- WrData  out  8  FIFO head byte.
- EdgeCount  out  17  number of Dop==1 pixels accepted this frame.
- Busy  out  1  high in RUN and FLUSH.
- Done  out  1  high in DONE.
- Overflow  out  1  sticky; a byte was dropped because the FIFO was full.

Behaviour:
- Reset (RST=1 at a CLK edge, in any state):
  - State goes to IDLE; FIFO, shift register, bit index, pixel counter, WrAddr, EdgeCount and Overflow clear.
  - Outputs: WrEn=0, WrData=0, Busy=0, Done=0. A partial frame is discarded, with no write.
- IDLE:
  - Valid is ignored.
  - Start=1 moves to RUN next cycle and clears the counters, WrAddr, EdgeCount and Overflow.
- RUN: on each cycle with Valid=1:
  - Dop goes into shift bit[bitidx]; bitidx increments mod 8; EdgeCount += Dop; pixel counter increments.
  - When bitidx==7, or the pixel is the last one (count==IMG_W*IMG_H-1), the completed byte is pushed into the FIFO that same edge. Unfilled high bits of a final partial byte are 0.
  - After the last pixel, move to FLUSH.
- FLUSH:
  - Valid is ignored.
  - Move to DONE on the first cycle the FIFO is empty (after the final pop).
- DONE:
  - Done=1; WrEn=0.
  - Move to IDLE when Start=0. Start held high does not restart a frame.
- FIFO and write port:
  - WrEn=!empty; WrData and WrAddr are combinational from the head entry and the write counter.
  - A write is accepted when WrEn && WrReady; on acceptance pop the head and WrAddr += 1.
  - WrAddr wraps mod 2^ADDR_W.
- Latency: the byte completed on the Valid cycle at edge N shows WrEn=1 from edge N+1 when the FIFO was empty. The first write address of a frame is 0.
- Simultaneous push and pop:
  - Always legal. Occupancy is unchanged; allowed even when the FIFO is full, with no overflow.
- Push into a full FIFO without a same-cycle pop:
  - The byte is dropped and Overflow sets. Overflow holds until RST or the next Start.
  - The frame continues; EdgeCount still counts the dropped pixels.
- WrEn/WrData must stay stable while WrReady=0, until accepted.
- Valid gaps of any length in RUN are allowed; there is no timeout.
- EdgeCount saturates at 2^17-1 and is not cleared on DONE; it is held until the next Start.

Test Plan (IMG_W=4, IMG_H=4, FIFO_DEPTH=4 unless noted):
- Start, 16 Valid pixels with Dop=1,0,1,1,0,0,0,1, 1,1,1,1,1,1,1,1, WrReady=1 -> writes (0,0x8D) then (1,0xFF); EdgeCount=12; Done=1 after the second write; Overflow=0.
- Same stimulus with WrReady=0 until 10 cycles after the last pixel -> FIFO holds 2 bytes; WrEn/WrData stable; writes then complete in order; then DONE.
- IMG_W=3, IMG_H=3, all Dop=1 -> writes (0,0xFF), (1,0x01); EdgeCount=9.
- FIFO_DEPTH=2, WrReady=0 for the whole frame with IMG_W=8, IMG_H=4 -> third byte dropped; Overflow=1; only 2 writes after WrReady rises; Overflow cleared on the next Start.
- RST asserted mid-RUN after 5 pixels -> next edge: all outputs at reset values; new Start, 16 pixels -> addresses restart at 0.
- Start held high through DONE -> no restart; Start low -> IDLE; Valid pulses in IDLE/FLUSH/DONE change no counter.

Source files
------------

// File: rtl/sobel_edge_writer.sv
// Packs the Sobel core's per-pixel edge bits into bytes (LSB first), buffers them
// in a small FIFO and streams them to the edge-map memory over a valid/ready port.
module sobel_edge_writer #(
    parameter int IMG_W      = 256,
    parameter int IMG_H      = 256,
    parameter int ADDR_W     = 13,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Start,
    input  logic              Valid,
    input  logic              Dop,
    input  logic              WrReady,
    output logic              WrEn,
    output logic [ADDR_W-1:0] WrAddr,
    output logic [7:0]        WrData,
    output logic [16:0]       EdgeCount,
    output logic              Busy,
    output logic              Done,
    output logic              Overflow
);

    localparam int NPIX  = IMG_W * IMG_H;
    localparam int CNT_W = $clog2(NPIX + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [7:0]         shift_q;
    logic [2:0]         bit_idx_q;
    logic [CNT_W-1:0]   pix_cnt_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [16:0]        edge_cnt_q;
    logic               overflow_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [OCC_W-1:0]   occ_q;
    logic [7:0]         fifo_mem_q [FIFO_DEPTH];

    logic       pix_accept;
    logic       last_pix;
    logic       push;
    logic       pop;
    logic       full;
    logic       do_write;
    logic [7:0] byte_d;

    always_comb begin
        pix_accept = (state_q == S_RUN) && Valid;
        last_pix   = (pix_cnt_q == CNT_W'(NPIX - 1));
        push       = pix_accept && ((bit_idx_q == 3'd7) || last_pix);
        pop        = (occ_q != '0) && WrReady;
        full       = (occ_q == OCC_W'(FIFO_DEPTH));
        // A full FIFO still takes a byte if the head leaves on the same edge.
        do_write   = push && (!full || pop);
        byte_d            = shift_q;
        byte_d[bit_idx_q] = Dop;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            pix_cnt_q  <= '0;
            wr_addr_q  <= '0;
            edge_cnt_q <= '0;
            overflow_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            occ_q      <= '0;
        end else begin
            if (do_write) begin
                fifo_mem_q[wr_ptr_q] <= byte_d;
                wr_ptr_q             <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                wr_addr_q <= wr_addr_q + 1'b1;
            end
            if (do_write && !pop) begin
                occ_q <= occ_q + 1'b1;
            end else if (pop && !do_write) begin
                occ_q <= occ_q - 1'b1;
            end
            if (push && !do_write) begin
                overflow_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        state_q    <= S_RUN;
                        shift_q    <= '0;
                        bit_idx_q  <= '0;
                        pix_cnt_q  <= '0;
                        wr_addr_q  <= '0;
                        edge_cnt_q <= '0;
                        overflow_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (Valid) begin
                        bit_idx_q <= bit_idx_q + 1'b1;
                        pix_cnt_q <= pix_cnt_q + 1'b1;
                        shift_q   <= push ? 8'h00 : byte_d;
                        if (Dop && (edge_cnt_q != '1)) begin
                            edge_cnt_q <= edge_cnt_q + 1'b1;
                        end
                        if (last_pix) begin
                            state_q <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (occ_q == '0) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!Start) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign WrEn      = (occ_q != '0);
    assign WrData    = WrEn ? fifo_mem_q[rd_ptr_q] : 8'h00;
    assign WrAddr    = wr_addr_q;
    assign EdgeCount = edge_cnt_q;
    assign Busy      = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign Done      = (state_q == S_DONE);
    assign Overflow  = overflow_q;

endmodule

// File: tb/tb_sobel_edge_writer.sv
// Bench for sobel_edge_writer: three instances (4x4/depth4, 3x3/depth4, 8x4/depth2)
// checked against a frame-level packing model.
module tb_sobel_edge_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [2:0]        start, valid, dop, wr_ready;
    logic [2:0]        wr_en, busy, done, overflow;
    logic [2:0][12:0]  wr_addr;
    logic [2:0][7:0]   wr_data;
    logic [2:0][16:0]  edge_count;

    sobel_edge_writer #(.IMG_W(4), .IMG_H(4), .ADDR_W(13), .FIFO_DEPTH(4)) dut0 (
        .CLK(clk), .RST(rst), .Start(start[0]), .Valid(valid[0]), .Dop(dop[0]),
        .WrReady(wr_ready[0]), .WrEn(wr_en[0]), .WrAddr(wr_addr[0]), .WrData(wr_data[0]),
        .EdgeCount(edge_count[0]), .Busy(busy[0]), .Done(done[0]), .Overflow(overflow[0]));

    sobel_edge_writer #(.IMG_W(3), .IMG_H(3), .ADDR_W(13), .FIFO_DEPTH(4)) dut1 (
        .CLK(clk), .RST(rst), .Start(start[1]), .Valid(valid[1]), .Dop(dop[1]),
        .WrReady(wr_ready[1]), .WrEn(wr_en[1]), .WrAddr(wr_addr[1]), .WrData(wr_data[1]),
        .EdgeCount(edge_count[1]), .Busy(busy[1]), .Done(done[1]), .Overflow(overflow[1]));

    sobel_edge_writer #(.IMG_W(8), .IMG_H(4), .ADDR_W(13), .FIFO_DEPTH(2)) dut2 (
        .CLK(clk), .RST(rst), .Start(start[2]), .Valid(valid[2]), .Dop(dop[2]),
        .WrReady(wr_ready[2]), .WrEn(wr_en[2]), .WrAddr(wr_addr[2]), .WrData(wr_data[2]),
        .EdgeCount(edge_count[2]), .Busy(busy[2]), .Done(done[2]), .Overflow(overflow[2]));

    int checks = 0;
    int errors = 0;
    int wr_log[$];
    int exp_q[$];
    int exp_edges;
    bit dop_vec[64];

    // Accepted writes, encoded as (addr << 8) | data; only one instance is active at a time.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst && wr_en[d] && wr_ready[d]) begin
                wr_log.push_back((int'(wr_addr[d]) << 8) | int'(wr_data[d]));
            end
        end
    end

    // Frame model: bytes are raster bits packed LSB first; only the first 'keep' bytes survive.
    function automatic void model_frame(input int npix, input int keep);
        int nb;
        int b;
        exp_q.delete();
        exp_edges = 0;
        nb = (npix + 7) / 8;
        for (int k = 0; k < nb; k++) begin
            b = 0;
            for (int j = 0; j < 8; j++) begin
                if (8 * k + j < npix && dop_vec[8 * k + j]) b = b | (1 << j);
            end
            if (k < keep) exp_q.push_back((exp_q.size() << 8) | b);
        end
        for (int i = 0; i < npix; i++) exp_edges += int'(dop_vec[i]);
    endfunction

    function automatic logic ready_for(input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 1) return 1'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    task automatic drive_frame(input int d, input int npix, input bit gaps, input int mode);
        wr_log.delete();
        start[d] = 1'b0;
        valid[d] = 1'b0;
        @(negedge clk);
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        for (int i = 0; i < npix; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    valid[d] = 1'b0;
                    wr_ready[d] = ready_for(mode);
                    @(negedge clk);
                end
            end
            valid[d] = 1'b1;
            dop[d] = dop_vec[i];
            wr_ready[d] = ready_for(mode);
            @(negedge clk);
        end
        valid[d] = 1'b0;
        dop[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int mode);
        int n = 0;
        while (!done[d] && n < 300) begin
            wr_ready[d] = ready_for(mode);
            @(negedge clk);
            n++;
        end
        checks++;
        if (done[d] !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout dut%0d: Done=%b after %0d cycles, required 1", d, done[d], n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = '0; valid = '0; dop = '0; wr_ready = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            checks += 7;
            if (wr_en[d] !== 1'b0) begin errors++; $display("FAIL reset_wren dut%0d: got %b want 0", d, wr_en[d]); end
            if (wr_data[d] !== 8'h00) begin errors++; $display("FAIL reset_wrdata dut%0d: got %h want 00", d, wr_data[d]); end
            if (wr_addr[d] !== 13'd0) begin errors++; $display("FAIL reset_wraddr dut%0d: got %0d want 0", d, wr_addr[d]); end
            if (edge_count[d] !== 17'd0) begin errors++; $display("FAIL reset_edges dut%0d: got %0d want 0", d, edge_count[d]); end
            if (busy[d] !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d: got %b want 0", d, busy[d]); end
            if (done[d] !== 1'b0) begin errors++; $display("FAIL reset_done dut%0d: got %b want 0", d, done[d]); end
            if (overflow[d] !== 1'b0) begin errors++; $display("FAIL reset_ovf dut%0d: got %b want 0", d, overflow[d]); end
        end
        $display("test_reset: done");
    endtask

    task automatic load_directed();
        bit [15:0] pat;
        pat = 16'b1111_1111_1000_1101;
        for (int i = 0; i < 16; i++) dop_vec[i] = pat[i];
    endtask

    task automatic test_directed();
        load_directed();
        drive_frame(0, 16, 1'b0, 0);
        wait_done(0, 0);
        checks += 5;
        if (wr_log.size() !== 2) begin errors++; $display("FAIL dir_nwrites: got %0d want 2", wr_log.size()); end
        if (wr_log.size() > 0 && wr_log[0] !== 32'h008D) begin errors++; $display("FAIL dir_write0: got %h want 008d", wr_log[0]); end
        if (wr_log.size() > 1 && wr_log[1] !== 32'h01FF) begin errors++; $display("FAIL dir_write1: got %h want 01ff", wr_log[1]); end
        if (edge_count[0] !== 17'd12) begin errors++; $display("FAIL dir_edges: got %0d want 12", edge_count[0]); end
        if (overflow[0] !== 1'b0) begin errors++; $display("FAIL dir_ovf: got %b want 0", overflow[0]); end
        $display("test_directed: writes=%0d edges=%0d", wr_log.size(), edge_count[0]);
    endtask

    task automatic test_backpressure();
        load_directed();
        drive_frame(0, 16, 1'b0, 2);
        // FLUSH with the memory stalled; Valid pulses here must be ignored.
        for (int c = 0; c < 10; c++) begin
            wr_ready[0] = 1'b0;
            valid[0] = 1'b1;
            dop[0] = 1'b1;
            @(negedge clk);
            checks += 5;
            if (wr_en[0] !== 1'b1) begin errors++; $display("FAIL bp_wren c%0d: got %b want 1", c, wr_en[0]); end
            if (wr_data[0] !== 8'h8D) begin errors++; $display("FAIL bp_wrdata c%0d: got %h want 8d", c, wr_data[0]); end
            if (wr_addr[0] !== 13'd0) begin errors++; $display("FAIL bp_wraddr c%0d: got %0d want 0", c, wr_addr[0]); end
            if (done[0] !== 1'b0) begin errors++; $display("FAIL bp_done c%0d: got %b want 0", c, done[0]); end
            if (edge_count[0] !== 17'd12) begin errors++; $display("FAIL bp_edges c%0d: got %0d want 12", c, edge_count[0]); end
        end
        valid[0] = 1'b0;
        dop[0] = 1'b0;
        wait_done(0, 0);
        checks += 3;
        if (wr_log.size() !== 2) begin errors++; $display("FAIL bp_nwrites: got %0d want 2", wr_log.size()); end
        if (wr_log.size() > 0 && wr_log[0] !== 32'h008D) begin errors++; $display("FAIL bp_write0: got %h want 008d", wr_log[0]); end
        if (wr_log.size() > 1 && wr_log[1] !== 32'h01FF) begin errors++; $display("FAIL bp_write1: got %h want 01ff", wr_log[1]); end
        $display("test_backpressure: writes=%0d", wr_log.size());
    endtask

    task automatic test_partial_byte();
        for (int i = 0; i < 9; i++) dop_vec[i] = 1'b1;
        drive_frame(1, 9, 1'b0, 0);
        wait_done(1, 0);
        checks += 4;
        if (wr_log.size() !== 2) begin errors++; $display("FAIL part_nwrites: got %0d want 2", wr_log.size()); end
        if (wr_log.size() > 0 && wr_log[0] !== 32'h00FF) begin errors++; $display("FAIL part_write0: got %h want 00ff", wr_log[0]); end
        if (wr_log.size() > 1 && wr_log[1] !== 32'h0101) begin errors++; $display("FAIL part_write1: got %h want 0101", wr_log[1]); end
        if (edge_count[1] !== 17'd9) begin errors++; $display("FAIL part_edges: got %0d want 9", edge_count[1]); end
        $display("test_partial_byte: writes=%0d edges=%0d", wr_log.size(), edge_count[1]);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 32; i++) dop_vec[i] = 1'($urandom_range(0, 1));
        drive_frame(2, 32, 1'b1, 2);
        repeat (3) @(negedge clk);
        checks += 3;
        if (overflow[2] !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow[2]); end
        if (wr_en[2] !== 1'b1) begin errors++; $display("FAIL ovf_wren: got %b want 1", wr_en[2]); end
        if (busy[2] !== 1'b1) begin errors++; $display("FAIL ovf_busy: got %b want 1", busy[2]); end
        wait_done(2, 0);
        model_frame(32, 2);
        checks += 3;
        if (wr_log.size() !== exp_q.size()) begin errors++; $display("FAIL ovf_nwrites: got %0d want %0d", wr_log.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (k >= wr_log.size() || wr_log[k] !== exp_q[k]) begin
                errors++; $display("FAIL ovf_write%0d: got %h want %h", k, (k < wr_log.size()) ? wr_log[k] : -1, exp_q[k]);
            end
        end
        if (edge_count[2] !== 17'(exp_edges)) begin errors++; $display("FAIL ovf_edges: got %0d want %0d", edge_count[2], exp_edges); end
        if (overflow[2] !== 1'b1) begin errors++; $display("FAIL ovf_hold: got %b want 1", overflow[2]); end
        $display("test_overflow: writes=%0d overflow=%b", wr_log.size(), overflow[2]);
        // The next Start clears the sticky flag; this frame never stalls.
        for (int i = 0; i < 32; i++) dop_vec[i] = 1'($urandom_range(0, 1));
        drive_frame(2, 32, 1'b1, 0);
        wait_done(2, 0);
        model_frame(32, 99);
        checks += 3;
        if (overflow[2] !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", overflow[2]); end
        if (wr_log.size() !== 4) begin errors++; $display("FAIL ovf2_nwrites: got %0d want 4", wr_log.size()); end
        if (edge_count[2] !== 17'(exp_edges)) begin errors++; $display("FAIL ovf2_edges: got %0d want %0d", edge_count[2], exp_edges); end
        $display("test_overflow: second frame writes=%0d overflow=%b", wr_log.size(), overflow[2]);
    endtask

    task automatic test_reset_mid_run();
        wr_log.delete();
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            valid[0] = 1'b1; dop[0] = 1'b1; wr_ready[0] = 1'b1;
            @(negedge clk);
        end
        valid[0] = 1'b0;
        checks += 2;
        if (busy[0] !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy[0]); end
        if (edge_count[0] !== 17'd5) begin errors++; $display("FAIL mid_edges: got %0d want 5", edge_count[0]); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks += 6;
        if (busy[0] !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy[0]); end
        if (edge_count[0] !== 17'd0) begin errors++; $display("FAIL mid_rst_edges: got %0d want 0", edge_count[0]); end
        if (wr_addr[0] !== 13'd0) begin errors++; $display("FAIL mid_rst_addr: got %0d want 0", wr_addr[0]); end
        if (wr_en[0] !== 1'b0) begin errors++; $display("FAIL mid_rst_wren: got %b want 0", wr_en[0]); end
        if (done[0] !== 1'b0) begin errors++; $display("FAIL mid_rst_done: got %b want 0", done[0]); end
        if (wr_log.size() !== 0) begin errors++; $display("FAIL mid_rst_nowrite: got %0d writes want 0", wr_log.size()); end
        for (int i = 0; i < 16; i++) dop_vec[i] = 1'($urandom_range(0, 1));
        drive_frame(0, 16, 1'b1, 0);
        wait_done(0, 0);
        model_frame(16, 99);
        checks += 2;
        if (wr_log.size() !== exp_q.size()) begin errors++; $display("FAIL mid_nwrites: got %0d want %0d", wr_log.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (k >= wr_log.size() || wr_log[k] !== exp_q[k]) begin
                errors++; $display("FAIL mid_write%0d: got %h want %h", k, (k < wr_log.size()) ? wr_log[k] : -1, exp_q[k]);
            end
        end
        if (edge_count[0] !== 17'(exp_edges)) begin errors++; $display("FAIL mid_edges2: got %0d want %0d", edge_count[0], exp_edges); end
        $display("test_reset_mid_run: writes=%0d edges=%0d", wr_log.size(), edge_count[0]);
    endtask

    task automatic test_start_held();
        for (int i = 0; i < 16; i++) dop_vec[i] = 1'($urandom_range(0, 1));
        drive_frame(0, 16, 1'b0, 0);
        model_frame(16, 99);
        start[0] = 1'b1;
        wait_done(0, 0);
        for (int c = 0; c < 6; c++) begin
            valid[0] = 1'b1; dop[0] = 1'b1;
            @(negedge clk);
            checks += 3;
            if (done[0] !== 1'b1) begin errors++; $display("FAIL held_done c%0d: got %b want 1", c, done[0]); end
            if (busy[0] !== 1'b0) begin errors++; $display("FAIL held_busy c%0d: got %b want 0", c, busy[0]); end
            if (edge_count[0] !== 17'(exp_edges)) begin errors++; $display("FAIL held_edges c%0d: got %0d want %0d", c, edge_count[0], exp_edges); end
        end
        valid[0] = 1'b0;
        start[0] = 1'b0;
        @(negedge clk);
        checks += 2;
        if (done[0] !== 1'b0) begin errors++; $display("FAIL held_idle_done: got %b want 0", done[0]); end
        if (busy[0] !== 1'b0) begin errors++; $display("FAIL held_idle_busy: got %b want 0", busy[0]); end
        for (int c = 0; c < 4; c++) begin
            valid[0] = 1'b1; dop[0] = 1'b1;
            @(negedge clk);
            checks += 3;
            if (busy[0] !== 1'b0) begin errors++; $display("FAIL idle_busy c%0d: got %b want 0", c, busy[0]); end
            if (wr_en[0] !== 1'b0) begin errors++; $display("FAIL idle_wren c%0d: got %b want 0", c, wr_en[0]); end
            if (edge_count[0] !== 17'(exp_edges)) begin errors++; $display("FAIL idle_edges c%0d: got %0d want %0d", c, edge_count[0], exp_edges); end
        end
        valid[0] = 1'b0;
        dop[0] = 1'b0;
        $display("test_start_held: edges=%0d", edge_count[0]);
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 16; i++) dop_vec[i] = 1'($urandom_range(0, 1));
            drive_frame(0, 16, 1'b1, 1);
            wait_done(0, 1);
            model_frame(16, 99);
            checks += 3;
            if (wr_log.size() !== exp_q.size()) begin errors++; $display("FAIL rnd%0d_nwrites: got %0d want %0d", f, wr_log.size(), exp_q.size()); end
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++;
                if (k >= wr_log.size() || wr_log[k] !== exp_q[k]) begin
                    errors++; $display("FAIL rnd%0d_write%0d: got %h want %h", f, k, (k < wr_log.size()) ? wr_log[k] : -1, exp_q[k]);
                end
            end
            if (edge_count[0] !== 17'(exp_edges)) begin errors++; $display("FAIL rnd%0d_edges: got %0d want %0d", f, edge_count[0], exp_edges); end
            if (overflow[0] !== 1'b0) begin errors++; $display("FAIL rnd%0d_ovf: got %b want 0", f, overflow[0]); end
            $display("test_random_frames: frame %0d writes=%0d edges=%0d", f, wr_log.size(), edge_count[0]);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_partial_byte();
        test_overflow();
        test_reset_mid_run();
        test_start_held();
        test_random_frames();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
